// File: rtl/pico_qsys_pkg.sv
// Shared constants for the pico_qsys switch path: clock rate, debounce window
// and switch bus width, plus the counter-width helper used by the debouncer.
package pico_qsys_pkg;

   localparam int CLK_FREQ_HZ     = 50_000_000;
   localparam int DEBOUNCE_MS     = 1;
   localparam int DEBOUNCE_CYCLES = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
   localparam int SW_WIDTH        = 8;

   // A one-cycle window still needs a 1-bit counter to keep the datapath legal.
   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n);
      if (w < 1) begin
         return 1;
      end else begin
         return w;
      end
   endfunction

endpackage

// File: rtl/pico_qsys_sw_debounce_bit.sv
// Single switch channel: synchroniser chain, persistence counter, stable level
// register and registered one-cycle rise/fall pulses.
module pico_qsys_sw_debounce_bit
   import pico_qsys_pkg::*;
#(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 4,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sw_raw,
   output logic sw_db,
   output logic sw_rise,
   output logic sw_fall,
   output logic pulse_nxt
);

   localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_db;
   logic                   r_rise;
   logic                   r_fall;

   logic                   w_sync;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic                   w_db_nxt;
   logic                   w_rise_nxt;
   logic                   w_fall_nxt;

   assign w_sync = r_sync[SYNC_STAGES-1];

   // Next-state: any sample matching the stable level restarts the window.
   always_comb begin
      w_cnt_nxt  = {CNT_W{1'b0}};
      w_db_nxt   = r_db;
      w_rise_nxt = 1'b0;
      w_fall_nxt = 1'b0;
      if (w_sync == r_db) begin
         w_cnt_nxt = {CNT_W{1'b0}};
      end else if (r_cnt == CNT_MAX) begin
         w_db_nxt   = w_sync;
         w_cnt_nxt  = {CNT_W{1'b0}};
         w_rise_nxt = w_sync;
         w_fall_nxt = ~w_sync;
      end else begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sync <= {SYNC_STAGES{RESET_VAL}};
         r_cnt  <= {CNT_W{1'b0}};
         r_db   <= RESET_VAL;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], sw_raw};
         r_cnt  <= w_cnt_nxt;
         r_db   <= w_db_nxt;
         r_rise <= w_rise_nxt;
         r_fall <= w_fall_nxt;
      end
   end

   assign sw_db     = r_db;
   assign sw_rise   = r_rise;
   assign sw_fall   = r_fall;
   assign pulse_nxt = w_rise_nxt | w_fall_nxt;

endmodule

// File: rtl/pico_qsys_sw_debounce.sv
// Debounces WIDTH raw switch inputs for the PIO in_port and flags accepted
// level changes with per-bit rise/fall pulses and a combined change strobe.
module pico_qsys_sw_debounce
   import pico_qsys_pkg::*;
#(
   parameter int               WIDTH           = SW_WIDTH,
   parameter int               SYNC_STAGES     = 2,
   parameter int               DEBOUNCE_CYCLES = pico_qsys_pkg::DEBOUNCE_CYCLES,
   parameter logic [WIDTH-1:0] RESET_VAL       = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_db,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             sw_changed
);

   logic [WIDTH-1:0] w_db;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_pulse_nxt;
   logic             r_changed;

   for (genvar g = 0; g < WIDTH; g++) begin : g_ch
      pico_qsys_sw_debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL       (RESET_VAL[g])
      ) u_bit (
         .clk       (clk),
         .reset_n   (reset_n),
         .sw_raw    (sw_raw[g]),
         .sw_db     (w_db[g]),
         .sw_rise   (w_rise[g]),
         .sw_fall   (w_fall[g]),
         .pulse_nxt (w_pulse_nxt[g])
      );
   end

   // Change strobe is built from next-state pulses so it lines up with them.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_changed <= 1'b0;
      end else begin
         r_changed <= |w_pulse_nxt;
      end
   end

   assign sw_db      = w_db;
   assign sw_rise    = w_rise;
   assign sw_fall    = w_fall;
   assign sw_changed = r_changed;

endmodule

// File: tb/tb_pico_qsys_sw_debounce.sv
// Directed bench: one 8-bit debouncer with a 4-cycle window and one with a
// 1-cycle window, sharing clock and reset.
module tb_pico_qsys_sw_debounce;

   logic       clk;
   logic       reset_n;
   logic [7:0] sw_raw;
   logic [7:0] sw_db;
   logic [7:0] sw_rise;
   logic [7:0] sw_fall;
   logic       sw_changed;

   logic [7:0] sw_raw1;
   logic [7:0] sw_db1;
   logic [7:0] sw_rise1;
   logic [7:0] sw_fall1;
   logic       sw_changed1;

   int n_tests = 0;
   int n_fail  = 0;

   pico_qsys_sw_debounce #(
      .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VAL(8'h00)
   ) u_dut (
      .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw), .sw_db(sw_db),
      .sw_rise(sw_rise), .sw_fall(sw_fall), .sw_changed(sw_changed)
   );

   pico_qsys_sw_debounce #(
      .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_VAL(8'h00)
   ) u_dut1 (
      .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw1), .sw_db(sw_db1),
      .sw_rise(sw_rise1), .sw_fall(sw_fall1), .sw_changed(sw_changed1)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic expect_all(input string tag, input logic [7:0] e_db,
                             input logic [7:0] e_rise, input logic [7:0] e_fall,
                             input logic e_ch);
      chk({tag, ".db"},   sw_db,   e_db);
      chk({tag, ".rise"}, sw_rise, e_rise);
      chk({tag, ".fall"}, sw_fall, e_fall);
      chk({tag, ".chg"},  {7'd0, sw_changed}, {7'd0, e_ch});
   endtask

   // Apply a new raw level and walk the full 6-edge acceptance latency.
   task automatic run_latency(input string tag, input logic [7:0] new_raw,
                              input logic [7:0] old_db);
      logic [7:0] e_rise;
      logic [7:0] e_fall;
      e_rise = new_raw & ~old_db;
      e_fall = ~new_raw & old_db;
      sw_raw = new_raw;
      for (int k = 1; k <= 5; k++) begin
         tick();
         expect_all($sformatf("%s.e%0d", tag, k), old_db, 8'h00, 8'h00, 1'b0);
      end
      tick();
      expect_all({tag, ".e6"}, new_raw, e_rise, e_fall, |(e_rise | e_fall));
      tick();
      expect_all({tag, ".e7"}, new_raw, 8'h00, 8'h00, 1'b0);
   endtask

   initial begin
      clk     = 1'b0;
      reset_n = 1'b0;
      sw_raw  = 8'hFF;
      sw_raw1 = 8'h00;

      // 1: reset with raw high, then full latency after release
      for (int k = 0; k < 3; k++) begin
         tick();
         expect_all("t1.rst", 8'h00, 8'h00, 8'h00, 1'b0);
      end
      reset_n = 1'b1;
      run_latency("t1.up", 8'hFF, 8'h00);
      run_latency("t1.dn", 8'h00, 8'hFF);

      // 2: bounce on bit0, then steady high
      for (int k = 0; k < 6; k++) begin
         sw_raw = (k % 2 == 0) ? 8'h01 : 8'h00;
         tick();
         expect_all($sformatf("t2.bnc%0d", k), 8'h00, 8'h00, 8'h00, 1'b0);
      end
      run_latency("t2.hold", 8'h01, 8'h00);

      // 3: bit3 glitch one cycle shorter than the window
      sw_raw = 8'h09;
      for (int k = 0; k < 3; k++) begin
         tick();
         expect_all($sformatf("t3.hi%0d", k), 8'h01, 8'h00, 8'h00, 1'b0);
      end
      sw_raw = 8'h01;
      for (int k = 0; k < 8; k++) begin
         tick();
         expect_all($sformatf("t3.lo%0d", k), 8'h01, 8'h00, 8'h00, 1'b0);
      end

      // 4: simultaneous rises and falls
      run_latency("t4.pre", 8'h0F, 8'h01);
      run_latency("t4.swap", 8'hF0, 8'h0F);

      // 5: reset in the middle of a window on bit7
      run_latency("t5.clr", 8'h00, 8'hF0);
      sw_raw = 8'h80;
      for (int k = 1; k <= 4; k++) begin
         tick();
         expect_all($sformatf("t5.w%0d", k), 8'h00, 8'h00, 8'h00, 1'b0);
      end
      reset_n = 1'b0;
      tick();
      expect_all("t5.rst", 8'h00, 8'h00, 8'h00, 1'b0);
      reset_n = 1'b1;
      run_latency("t5.post", 8'h80, 8'h00);

      // 6: one-cycle window instance
      chk("t6.db0", sw_db1, 8'h00);
      sw_raw1 = 8'h01;
      for (int k = 1; k <= 2; k++) begin
         tick();
         chk($sformatf("t6.db.e%0d", k), sw_db1, 8'h00);
         chk($sformatf("t6.rise.e%0d", k), sw_rise1, 8'h00);
      end
      tick();
      chk("t6.db.e3", sw_db1, 8'h01);
      chk("t6.rise.e3", sw_rise1, 8'h01);
      chk("t6.fall.e3", sw_fall1, 8'h00);
      chk("t6.chg.e3", {7'd0, sw_changed1}, 8'h01);
      tick();
      chk("t6.db.e4", sw_db1, 8'h01);
      chk("t6.rise.e4", sw_rise1, 8'h00);
      chk("t6.chg.e4", {7'd0, sw_changed1}, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
